// File: rtl/int_ctrl_pkg.sv
// Shared types and defaults for the interrupt controller.
// Imported by the controller top and its priority encoder.
package int_ctrl_pkg;

  localparam int NSRC_DEF = 4;
  localparam int IDW_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

endpackage

// File: rtl/int_prio_enc.sv
// Lowest-index-wins priority encoder.
// Reports whether any request bit is set.
module int_prio_enc
  import int_ctrl_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic [NSRC-1:0] i_req,
  output logic [IDW-1:0]  o_idx,
  output logic            o_vld
);

  // Scan high to low so the lowest set bit is written last.
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx = IDW'(i);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/int_ctrl.sv
// Multi-source interrupt controller.
// Drives the single core interrupt input with ack/eoi handshake.
module int_ctrl
  import int_ctrl_pkg::*;
#(
  parameter int NSRC = NSRC_DEF,
  parameter int IDW  = IDW_DEF
) (
  input  logic            ck,
  input  logic            res,
  input  logic [NSRC-1:0] src,
  input  logic [NSRC-1:0] edge_sel,
  input  logic            mask_we,
  input  logic [NSRC-1:0] mask_wd,
  output logic [NSRC-1:0] mask,
  output logic [NSRC-1:0] pending,
  output logic            int_req,
  output logic [IDW-1:0]  int_id,
  input  logic            int_ack,
  input  logic            eoi,
  output logic            busy
);

  state_t r_state;
  state_t w_state_nxt;

  logic [NSRC-1:0] r_src_q;
  logic [NSRC-1:0] r_mask;
  logic [NSRC-1:0] r_pend;
  logic [NSRC-1:0] w_rise;
  logic [NSRC-1:0] w_elig;
  logic [NSRC-1:0] w_ack_clr;
  logic [NSRC-1:0] w_pend_nxt;
  logic [IDW-1:0]  r_id;
  logic [IDW-1:0]  w_win;
  logic            w_win_vld;
  logic            w_ack_ok;
  logic            w_id_ld;

  assign w_rise   = src & ~r_src_q;
  assign w_elig   = r_pend & ~r_mask;
  assign w_ack_ok = (r_state == REQ) & int_ack;

  int_prio_enc #(
    .NSRC (NSRC),
    .IDW  (IDW)
  ) u_enc (
    .i_req (w_elig),
    .o_idx (w_win),
    .o_vld (w_win_vld)
  );

  always_comb begin
    w_ack_clr = '0;
    if (w_ack_ok) begin
      w_ack_clr[r_id] = 1'b1;
    end
  end

  // Edge sources: set beats ack-clear. Level sources track src_q.
  assign w_pend_nxt =
    (edge_sel & ((r_pend & ~w_ack_clr) | w_rise)) |
    (~edge_sel & r_src_q);

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      r_src_q <= '0;
      r_pend  <= '0;
      r_mask  <= '1;
    end else begin
      r_src_q <= src;
      r_pend  <= w_pend_nxt;
      if (mask_we) begin
        r_mask <= mask_wd;
      end
    end
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    int_req     = 1'b0;
    busy        = 1'b0;
    w_id_ld     = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_id_ld     = 1'b1;
          w_state_nxt = REQ;
        end
      end
      REQ: begin
        int_req = 1'b1;
        if (int_ack) begin
          w_state_nxt = SERVICE;
        end
      end
      SERVICE: begin
        busy = 1'b1;
        if (eoi) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // The id is captured once per request and held through service.
  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      r_id <= '0;
    end else if (w_id_ld) begin
      r_id <= w_win;
    end
  end

  assign mask    = r_mask;
  assign pending = r_pend;
  assign int_id  = r_id;

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Multi-source interrupt controller in front of the processor core's single interrupt input.
- Latches per-source requests (edge or level), applies a software mask and picks one source by fixed priority.
- Presents the chosen source to the core as int_req and int_id, and sequences the request/acknowledge/end-of-interrupt handshake.
- One interrupt is in service at a time; there is no nesting.

Parameters:
- NSRC, 4, number of interrupt sources.
- IDW, 2, width of int_id; must satisfy 2**IDW >= NSRC.

Ports:
- ck  in  1  system clock; all state updates on the rising edge.
- res  in  1  asynchronous, active-low reset.
- src  in  NSRC  raw interrupt lines, already synchronous to ck.
- edge_sel  in  NSRC  per-source mode, static: 1 = rising-edge, 0 = level-high.
- mask_we  in  1  mask write strobe.
- mask_wd  in  NSRC  mask write data; 1 = source masked.
- mask  out  NSRC  current mask register.
- pending  out  NSRC  current pending register.
- int_req  out  1  interrupt request to the core.
- int_id  out  IDW  index of the requested or in-service source.
- int_ack  in  1  core acknowledge, a one-cycle pulse.
- eoi  in  1  end-of-interrupt pulse from the handler.
- busy  out  1  high while an interrupt is in service.

Behaviour:
- Reset (res=0, asynchronous):
  - mask = all ones; pending = 0; src_q = 0.
  - state = IDLE; int_req = 0; int_id = 0; busy = 0.
  - Reset asserted mid-handshake abandons the handshake with no residue.
- Edge detect:
  - src_q <= src every cycle.
  - Rising edge for source i is src[i] & ~src_q[i].
- Pending, edge mode (edge_sel[i]=1):
  - Set on a detected rising edge.
  - Cleared when int_ack is accepted with int_id == i.
  - A set and a clear in the same cycle: set wins.
- Pending, level mode (edge_sel[i]=0):
  - pending[i] follows registered src[i] (one cycle late).
  - Never cleared by int_ack.
- Masking:
  - mask <= mask_wd on mask_we.
  - Masking does not clear pending; it only removes the source from arbitration.
- Eligibility and priority:
  - elig = pending & ~mask.
  - Fixed priority: lowest index wins.
- FSM, IDLE:
  - int_req = 0, busy = 0.
  - If elig != 0: int_id <= encoded winner, go to REQ.
- FSM, REQ:
  - int_req = 1; int_id is held.
  - The request is latched: later mask writes, level drops or new higher-priority arrivals do not withdraw or change it.
  - On int_ack: clear pending per the edge/level rules, go to SERVICE.
- FSM, SERVICE:
  - int_req = 0, busy = 1, int_id is held.
  - On eoi: go to IDLE.
- Ignored strobes:
  - int_ack outside REQ.
  - eoi outside SERVICE.
  - eoi and int_ack arriving together in REQ are handled as ack only.
- Latency:
  - Edge source: src sampled high at edge k sets pending at k, and int_req is high after edge k+1 (2 cycles).
  - Level source: 1 cycle later than an edge source.
- Re-arbitration:
  - Returning to IDLE on eoi re-arbitrates on the next cycle.
  - A still-high level source re-requests 1 cycle after the return to IDLE.
- Mask write and arbitration in the same cycle: arbitration uses the old mask.

Decomposition:
- Package int_ctrl_pkg:
  - State enum {IDLE, REQ, SERVICE}, 2-bit encoding.
  - Default NSRC and IDW constants.
- One sub-module, int_prio_enc:
  - Combinational NSRC-to-IDW lowest-index priority encoder with a valid output.
  - Instantiated once for the winner selection.

Test Plan:
- Reset, then mask_wd=4'b0000 with mask_we, then src[2] edge -> int_req=1 two cycles later, int_id=2; int_ack -> pending[2]=0, busy=1; eoi -> busy=0, int_req stays 0.
- Edge pulses on src[3] and src[1] in the same cycle -> int_id=1 first; after ack and eoi, int_id=3 with int_req=1.
- Level src[0] held high, mask open -> int_id=0 request; ack leaves pending[0]=1; after eoi, int_req re-asserts 1 cycle after IDLE; drop src[0] -> no further request.
- src[1] edge with mask[1]=1 -> pending[1]=1, int_req=0; write mask[1]=0 -> int_req=1 after 1 cycle, int_id=1.
- In REQ with int_id=2, assert mask[2]=1 and pulse src[0] -> int_id stays 2, int_req stays 1 until ack.
- Drop res mid-SERVICE -> all outputs 0, mask=4'b1111, pending=0 immediately (asynchronously); stray eoi after release is ignored.
